// File: rtl/fifo_pkg.sv
// Shared defaults, pointer sizing and status type for the read-address FIFO.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 16;
  localparam int FIFO_DEF_DEPTH = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_queue_if.sv
// Push/pop handshake bundle between a request port and its address FIFO.
interface fifo_queue_if #(
  parameter int WIDTH = fifo_pkg::FIFO_DEF_WIDTH
);
  logic             push;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             pop;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             flush;

  modport master (
    output push, din, pop, flush,
    input  full, dout, empty
  );

  modport slave (
    input  push, din, pop, flush,
    output full, dout, empty
  );
endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH,
  localparam int AW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_queue.sv
// Single-clock FIFO for pending read addresses with registered head output and flush.
// Define FIFO_ASSERT_EN to stop simulation on overflow/underflow attempts.
module fifo_queue
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH
) (
  input logic          clk,
  input logic          rst_n,
  fifo_queue_if.slave  bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rdata;
  logic             push_acc, pop_acc;
  fifo_status_t     status;

  assign status.full  = (count_q == CW'(DEPTH));
  assign status.empty = (count_q == '0);

  // Flush wins over both operations, so neither is accepted in a flush cycle.
  assign push_acc = bus.push && !status.full  && !bus.flush;
  assign pop_acc  = bus.pop  && !status.empty && !bus.flush;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_acc),
    .waddr (tail_q),
    .wdata (bus.din),
    .raddr (head_q),
    .rdata (rdata)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_acc) tail_d = tail_q + PW'(1);
      if (pop_acc) begin
        head_d = head_q + PW'(1);
        dout_d = rdata;
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.full  = status.full;
  assign bus.empty = status.empty;
  assign bus.dout  = dout_q;

`ifdef FIFO_ASSERT_EN
  always @(posedge clk) begin
    if (rst_n && !bus.flush) begin
      if (bus.push && status.full) begin
        $display("fifo overflow");
        $finish;
      end
      if (bus.pop && status.empty) begin
        $display("fifo underflow");
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_queue.sv
// Directed bench for fifo_queue: vector table plus full/wrap, flush and async-reset sequences.
module tb_fifo_queue;
  import fifo_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fifo_queue_if #(.WIDTH(16)) bus ();

  fifo_queue #(
    .WIDTH (16),
    .DEPTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic        pop;
    logic        flush;
    logic [15:0] din;
    logic        e_empty;
    logic        e_full;
    logic [15:0] e_dout;
    string       name;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic push, input logic pop, input logic flush, input logic [15:0] din);
    bus.push  = push;
    bus.pop   = pop;
    bus.flush = flush;
    bus.din   = din;
    @(posedge clk);
    #1;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic chk_status(input string name, input logic e_empty, input logic e_full,
                            input logic [15:0] e_dout);
    chk({name, "/empty"}, 16'(bus.empty), 16'(e_empty));
    chk({name, "/full"},  16'(bus.full),  16'(e_full));
    chk({name, "/dout"},  bus.dout,       e_dout);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //         push pop flush din       empty full dout
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, "push10"};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b0, 16'h0000, "push20"};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 16'h0000, "push30"};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0010, "pop10"};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0020, "pop20"};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, "pop30"};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, "underflow"};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0044, 1'b0, 1'b0, 16'h0030, "pushpop_empty"};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0055, 1'b0, 1'b0, 16'h0030, "push55"};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0066, 1'b0, 1'b0, 16'h0044, "pushpop_two"};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0055, "pop55"};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0066, "pop66"};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0077, 1'b0, 1'b0, 16'h0066, "push77"};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 16'h0088, 1'b0, 1'b0, 16'h0066, "push88"};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0099, 1'b0, 1'b0, 16'h0066, "push99"};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 16'h0BAD, 1'b1, 1'b0, 16'h0066, "flush"};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 16'h0066, "push_after_flush"};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0123, "pop_after_flush"};

    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.flush = 1'b0;
    bus.din   = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 1'b1, 1'b0, 16'h0000);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk_status("post_reset", 1'b1, 1'b0, 16'h0000);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].din);
      chk_status(vecs[i].name, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_dout);
    end

    // Fill to full with a wrapped tail, then try to overflow.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i));
    chk_status("filled", 1'b0, 1'b1, 16'h0123);
    step(1'b1, 1'b0, 1'b0, 16'hFFFF);
    chk_status("overflow", 1'b0, 1'b1, 16'h0123);

    // First pop carries a push that must be dropped because the queue is full.
    step(1'b1, 1'b1, 1'b0, 16'hBBBB);
    chk_status("pushpop_full", 1'b0, 1'b0, 16'h0100);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      chk({"drain", "/dout"}, bus.dout, 16'h0100 + 16'(i));
    end
    chk_status("drained", 1'b1, 1'b0, 16'h0107);

    step(1'b1, 1'b0, 1'b0, 16'hAAAA);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_status("wrap", 1'b1, 1'b0, 16'hAAAA);

    // Asynchronous reset between edges with four entries queued.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i));
    chk_status("pre_async", 1'b0, 1'b0, 16'hAAAA);
    #2;
    rst_n = 1'b0;
    #1;
    chk_status("async_reset", 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'h0333);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_status("after_async", 1'b1, 1'b0, 16'h0333);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
